// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory / UART program loader.
//   IMEM_ADDR_W       : default word-address width
//   DEPTH             : default number of 32-bit words (2**IMEM_ADDR_W)
//   imem_word_t       : 32-bit instruction word
//   imem_hword_t      : 16-bit halfword (one bank entry)
//   imem_prog_state_t : loader FSM states
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W = 10;
    localparam int unsigned DEPTH       = 2 ** IMEM_ADDR_W;

    typedef logic [31:0] imem_word_t;
    typedef logic [15:0] imem_hword_t;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE
    } imem_prog_state_t;

endpackage

// File: rtl/imem_hword_bank.sv
// 16-bit x 2**ADDR_W halfword RAM bank.
//   clk     : clock
//   rd_en   : read enable; rd_data holds when low
//   rd_addr : read word index
//   rd_data : registered read data (old data on same-address write)
//   wr_en   : write enable
//   wr_addr : write word index
//   wr_data : write data
module imem_hword_bank
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output imem_hword_t       rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  imem_hword_t       wr_data
);

    imem_hword_t mem [2 ** ADDR_W];
    imem_hword_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_prog_controller.sv
// Instruction-memory responder for the fetch stage plus UART program loader.
//   clk, Rst_n : clock, synchronous active-low reset
//   imem_en    : fetch read enable
//   imem_addr  : fetch byte address (halfword aligned, upper bits wrap)
//   imem_dout  : read data, 1-cycle latency
//   prog_req   : start a load (sampled in IDLE only)
//   rx_valid   : received-byte strobe
//   rx_data    : received byte
//   prog_ena   : high while loading
//   prog_done  : one-cycle pulse on successful load
//   prog_err   : sticky load error
module imem_prog_controller
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W      = IMEM_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic        imem_en,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_dout,
    input  logic        prog_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        prog_ena,
    output logic        prog_done,
    output logic        prog_err
);

    localparam int unsigned NWORDS = 2 ** ADDR_W;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

    imem_prog_state_t state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [23:0]      shift_q, shift_d;
    logic [ADDR_W:0]  len_q, len_d;
    logic [ADDR_W:0]  widx_q, widx_d;
    logic [7:0]       csum_q, csum_d;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic             err_q, err_d;
    logic             zero_q, zero_d;
    logic             sel_q, sel_d;

    logic             wr_en;
    imem_word_t       wr_word;
    imem_word_t       n_word;
    logic             timeout;

    logic [ADDR_W-1:0] rd_w, rd_w_inc, lo_rd_addr;
    logic              rd_en;
    imem_hword_t       lo_q, hi_q;
    logic              unused_addr;

    assign unused_addr = ^{imem_addr[31:ADDR_W+2], imem_addr[0]};

    // Straddling reads take the low half of the next word from the LO bank,
    // so the LO bank is addressed one word ahead when addr[1] is set.
    assign rd_w       = imem_addr[ADDR_W+1:2];
    assign rd_w_inc   = rd_w + 1'b1;
    assign lo_rd_addr = imem_addr[1] ? rd_w_inc : rd_w;
    assign rd_en      = imem_en && !prog_ena;

    imem_hword_bank #(.ADDR_W(ADDR_W)) u_lo_bank (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (lo_rd_addr),
        .rd_data (lo_q),
        .wr_en   (wr_en),
        .wr_addr (widx_q[ADDR_W-1:0]),
        .wr_data (wr_word[15:0])
    );

    imem_hword_bank #(.ADDR_W(ADDR_W)) u_hi_bank (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_w),
        .rd_data (hi_q),
        .wr_en   (wr_en),
        .wr_addr (widx_q[ADDR_W-1:0]),
        .wr_data (wr_word[31:16])
    );

    // Bank outputs are already registered; zero_q/sel_q complete the output
    // register so dout reads as zero after reset/loading and holds when idle.
    assign imem_dout = zero_q ? '0 : (sel_q ? {lo_q, hi_q} : {hi_q, lo_q});
    assign prog_ena  = (state_q != IDLE);
    assign prog_done = (state_q == DONE);
    assign prog_err  = err_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        widx_d     = widx_q;
        csum_d     = csum_q;
        err_d      = err_q;
        zero_d     = zero_q;
        sel_d      = sel_q;
        wr_en      = 1'b0;
        n_word     = {rx_data, shift_q};
        wr_word    = {rx_data, shift_q};
        idle_d     = rx_valid ? '0 : idle_q + 1'b1;
        timeout    = !rx_valid && (idle_q == TO_W'(TIMEOUT_CYC - 1));

        if (prog_ena) begin
            zero_d = 1'b1;
        end else if (imem_en) begin
            zero_d = 1'b0;
            sel_d  = imem_addr[1];
        end

        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (prog_req) begin
                    state_d    = LEN;
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                    widx_d     = '0;
                    csum_d     = '0;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    shift_d    = {rx_data, shift_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        len_d = n_word[ADDR_W:0];
                        if (n_word > 32'(NWORDS)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else if (n_word == '0) begin
                            state_d = CSUM;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    shift_d    = {rx_data, shift_q[23:8]};
                    csum_d     = csum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en  = 1'b1;
                        widx_d = widx_q + 1'b1;
                        if (widx_q + 1'b1 == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            widx_q     <= '0;
            csum_q     <= '0;
            idle_q     <= '0;
            err_q      <= 1'b0;
            zero_q     <= 1'b1;
            sel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            csum_q     <= csum_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
            zero_q     <= zero_d;
            sel_q      <= sel_d;
        end
    end

endmodule
